div_wb_merge: RTL

DIV_WB_MERGE -- requirements
Module: div_wb_merge

---
 rtl/div_wb_merge_pkg.sv | 22 ++
 rtl/div_wb_merge_wb_fifo.sv | 58 +++++
 rtl/div_wb_merge.sv | 117 +++++++++++
 3 files changed

// File: rtl/div_wb_merge_pkg.sv
// Shared exe-stage definitions for the writeback merge: register/data widths,
// default pending-divide queue depth and the queued writeback entry type.
package div_wb_merge_pkg;

  localparam int REG_AW         = 5;
  localparam int DATA_W         = 32;
  localparam int NUM_REGS       = 1 << REG_AW;
  localparam int FIFO_DEPTH_DEF = 2;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] a);
    logic [NUM_REGS-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/div_wb_merge_wb_fifo.sv
// Pending divide-result queue: synchronous push/pop with wrapping pointers,
// occupancy count and full/empty flags. Head entry is presented combinationally.
module wb_fifo
  import div_wb_merge_pkg::*;
#(
  parameter int  DEPTH = FIFO_DEPTH_DEF,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic          pop,
  input  wb_entry_t     wdata,
  output wb_entry_t     rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full queue is legal only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/div_wb_merge.sv
// Merges single-cycle ALU results and divider results onto one registered
// register-file write port; tracks registers with a divide in flight.
module div_wb_merge
  import div_wb_merge_pkg::*;
#(
  parameter int  FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                alu_en,
  input  logic [REG_AW-1:0]   alu_addr,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic                div_en,
  input  logic [REG_AW-1:0]   div_addr,
  input  logic [DATA_W-1:0]   div_result,
  input  logic                div_issue_en,
  input  logic [REG_AW-1:0]   div_issue_addr,
  output logic                wb_en,
  output logic [REG_AW-1:0]   wb_addr,
  output logic [DATA_W-1:0]   wb_data,
  output logic [NUM_REGS-1:0] div_busy_mask,
  output logic                wb_hold,
  output logic                ovf_err
);

  logic [CW-1:0]       fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  wb_entry_t           fifo_head;
  wb_entry_t           div_entry;
  logic                fifo_pop;
  logic                fifo_push;
  logic                bypass;
  logic                drop;

  logic                sel_valid;
  logic                sel_div;
  logic [REG_AW-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic [NUM_REGS-1:0] clr_vec;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] mask_nxt;

  assign div_entry = '{addr: div_addr, data: div_result};

  // ALU owns the port whenever it is valid; queued divider results go before a new one.
  assign fifo_pop  = !fifo_empty && !alu_en;
  assign bypass    = div_en && fifo_empty && !alu_en;
  assign fifo_push = div_en && !bypass && (!fifo_full || fifo_pop);
  assign drop      = div_en && fifo_full && !fifo_pop;

  assign wb_hold = rstn && (fifo_full ||
                   ((fifo_count == CW'(FIFO_DEPTH - 1)) && div_en && alu_en));

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_wb_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (div_entry),
    .rdata (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_div   = 1'b0;
    sel_addr  = wb_addr;
    sel_data  = wb_data;
    if (alu_en) begin
      sel_valid = 1'b1;
      sel_addr  = alu_addr;
      sel_data  = alu_result;
    end else if (fifo_pop) begin
      sel_valid = 1'b1;
      sel_div   = 1'b1;
      sel_addr  = fifo_head.addr;
      sel_data  = fifo_head.data;
    end else if (bypass) begin
      sel_valid = 1'b1;
      sel_div   = 1'b1;
      sel_addr  = div_addr;
      sel_data  = div_result;
    end
  end

  // Set wins over clear so a re-issue to a register whose old result is leaving stays pending.
  always_comb begin
    clr_vec  = '0;
    set_vec  = '0;
    if (sel_div && (sel_addr != '0))
      clr_vec = reg_onehot(sel_addr);
    if (div_issue_en && (div_issue_addr != '0))
      set_vec = reg_onehot(div_issue_addr);
    mask_nxt = (div_busy_mask & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_en         <= 1'b0;
      wb_addr       <= '0;
      wb_data       <= '0;
      div_busy_mask <= '0;
      ovf_err       <= 1'b0;
    end else begin
      wb_en         <= sel_valid && (sel_addr != '0);
      wb_addr       <= sel_addr;
      wb_data       <= sel_data;
      div_busy_mask <= mask_nxt;
      if (drop) ovf_err <= 1'b1;
    end
  end

endmodule
